key_loader: RTL and testbench

Serial key-programming block that delivers the unlock key into a key-locked netlist. It hunts a bit stream for a frame header, shifts in KEY_W key bits and an even-parity bit, and commits the key to registered outputs that drive the locked circuit's key inputs p1..p4 and X_1..X_5. Failed frames are counted, and the block enters permanent lockout after MAX_FAIL consecutive failures.

---
 rtl/key_loader.sv | 234 +++++++++++++++++++++++
 tb/tb_key_loader.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/key_loader.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// key_loader
//
// Serial key-programming block. It hunts an incoming bit stream for an 8-bit
// frame header, then shifts in KEY_W key bits (MSB first) and one even-parity
// bit. A frame with good parity is committed to the registered key output
// that drives the locked netlist's key inputs. A frame with bad parity is
// counted. After MAX_FAIL consecutive bad frames the block locks out until
// reset.
//
// Key bit mapping onto the locked circuit:
//   key_o[0..3] = p1..p4, key_o[4..8] = X_1..X_5
//
// Ports
//   clk          in   clock, all state changes on the rising edge
//   rst_n        in   synchronous active-low reset
//   sin          in   serial data bit
//   sin_valid    in   sin carries a bit this cycle
//   sin_ready    out  block can take a bit this cycle (decoded from state)
//   key_o        out  committed key, registered
//   key_valid    out  a key has been committed since reset
//   load_done    out  one-cycle pulse on a successful commit
//   err          out  one-cycle pulse on a parity failure
//   locked       out  lockout, held until reset
//   dbg_state    out  current FSM state encoding (observation only)
//   dbg_fail_cnt out  consecutive-failure counter (observation only)
//
// Handshake: a bit transfers on a rising edge where sin_valid and sin_ready
// are both 1. sin_valid may drop for any number of cycles; nothing advances
// while it is low. sin_ready depends only on state, never on sin_valid.
// -----------------------------------------------------------------------------
module key_loader #(
  parameter int               KEY_W       = 9,
  parameter logic [7:0]       HDR         = 8'hA5,
  parameter int               MAX_FAIL    = 3,
  parameter logic [KEY_W-1:0] DEFAULT_KEY = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             sin,
  input  logic             sin_valid,
  output logic             sin_ready,
  output logic [KEY_W-1:0] key_o,
  output logic             key_valid,
  output logic             load_done,
  output logic             err,
  output logic             locked,
  output logic [2:0]       dbg_state,
  output logic [3:0]       dbg_fail_cnt
);

  typedef enum logic [2:0] {
    ST_HUNT    = 3'd0,
    ST_DATA    = 3'd1,
    ST_PARITY  = 3'd2,
    ST_COMMIT  = 3'd3,
    ST_LOCKOUT = 3'd4
  } state_t;

  localparam int               CNT_W    = $clog2(KEY_W + 1);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(KEY_W - 1);
  localparam logic [3:0]       FAIL_LIM = 4'(MAX_FAIL);

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  state_t           r_state;
  logic [7:0]       r_hdr_sr;
  logic [KEY_W-1:0] r_shadow;
  logic [CNT_W-1:0] r_bit_cnt;
  logic [3:0]       r_fail_cnt;
  logic [KEY_W-1:0] r_key;
  logic             r_key_valid;
  logic             r_load_done;
  logic             r_err;
  logic             r_locked;

  // ---------------------------------------------------------------------------
  // Combinational helpers
  // ---------------------------------------------------------------------------
  state_t     w_state_next;
  logic       w_ready;
  logic       w_accept;
  logic [7:0] w_hdr_next;
  logic       w_parity_ok;
  logic [3:0] w_fail_inc;

  assign w_ready    = (r_state == ST_HUNT) || (r_state == ST_DATA) ||
                      (r_state == ST_PARITY);
  assign w_accept   = sin_valid && w_ready;
  assign w_hdr_next = {r_hdr_sr[6:0], sin};

  // Even parity over the full frame: key bits plus the parity bit on sin.
  assign w_parity_ok = ~((^r_shadow) ^ sin);

  // Saturating increment; MAX_FAIL never exceeds 15 so lockout is still
  // reached before saturation matters.
  assign w_fail_inc = (r_fail_cnt == 4'hF) ? 4'hF : (r_fail_cnt + 4'd1);

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= ST_HUNT;
    end else begin
      r_state <= w_state_next;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next state
  // ---------------------------------------------------------------------------
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_HUNT: begin
        if (w_accept && (w_hdr_next == HDR)) begin
          w_state_next = ST_DATA;
        end
      end
      ST_DATA: begin
        if (w_accept && (r_bit_cnt == LAST_BIT)) begin
          w_state_next = ST_PARITY;
        end
      end
      ST_PARITY: begin
        if (w_accept) begin
          if (w_parity_ok) begin
            w_state_next = ST_COMMIT;
          end else if (w_fail_inc == FAIL_LIM) begin
            w_state_next = ST_LOCKOUT;
          end else begin
            w_state_next = ST_HUNT;
          end
        end
      end
      ST_COMMIT: begin
        w_state_next = ST_HUNT;
      end
      ST_LOCKOUT: begin
        w_state_next = ST_LOCKOUT;
      end
      default: begin
        w_state_next = ST_HUNT;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Datapath
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_hdr_sr    <= '0;
      r_shadow    <= '0;
      r_bit_cnt   <= '0;
      r_fail_cnt  <= '0;
      r_key       <= DEFAULT_KEY;
      r_key_valid <= 1'b0;
      r_load_done <= 1'b0;
      r_err       <= 1'b0;
      r_locked    <= 1'b0;
    end else begin
      // Pulses last exactly one cycle unless re-armed below.
      r_load_done <= 1'b0;
      r_err       <= 1'b0;

      case (r_state)
        ST_HUNT: begin
          if (w_accept) begin
            if (w_hdr_next == HDR) begin
              // Fresh window for the next hunt; counter starts the frame.
              r_hdr_sr  <= '0;
              r_bit_cnt <= '0;
            end else begin
              r_hdr_sr <= w_hdr_next;
            end
          end
        end
        ST_DATA: begin
          if (w_accept) begin
            r_shadow  <= {r_shadow[KEY_W-2:0], sin};
            r_bit_cnt <= r_bit_cnt + CNT_W'(1);
          end
        end
        ST_PARITY: begin
          if (w_accept) begin
            if (w_parity_ok) begin
              r_key       <= r_shadow;
              r_key_valid <= 1'b1;
              r_load_done <= 1'b1;
              r_fail_cnt  <= '0;
            end else begin
              r_err      <= 1'b1;
              r_fail_cnt <= w_fail_inc;
            end
          end
        end
        default: begin
          // COMMIT and LOCKOUT hold all datapath state.
        end
      endcase

      // Lockout is sticky because the FSM never leaves LOCKOUT.
      r_locked <= (w_state_next == ST_LOCKOUT);
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign sin_ready    = w_ready;
  assign key_o        = r_key;
  assign key_valid    = r_key_valid;
  assign load_done    = r_load_done;
  assign err          = r_err;
  assign locked       = r_locked;
  assign dbg_state    = r_state;
  assign dbg_fail_cnt = r_fail_cnt;

  // ---------------------------------------------------------------------------
  // Invariants
  // ---------------------------------------------------------------------------
  // A frame either commits or fails, never both.
  a_pulse_excl : assert property (@(posedge clk) disable iff (!rst_n)
    !(r_load_done && r_err));

  // Once locked, no bit is ever taken.
  a_locked_not_ready : assert property (@(posedge clk) disable iff (!rst_n)
    r_locked |-> !w_ready);

endmodule

// File: tb/tb_key_loader.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// tb_key_loader
//
// Directed bench for key_loader. A table of frames (optional leading garbage,
// header 0xA5, 9 key bits, parity bit) is streamed in order; after each
// parity edge the registered outputs are compared with hand-derived values.
// Hand-written sequences cover lockout, reset release and reset mid-frame.
// -----------------------------------------------------------------------------
module tb_key_loader;

  // ---------------------------------------------------------------------------
  // Clock / reset
  // ---------------------------------------------------------------------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n     = 1'b0;
  logic       sin       = 1'b0;
  logic       sin_valid = 1'b0;
  logic       sin_ready;
  logic [8:0] key_o;
  logic       key_valid;
  logic       load_done;
  logic       err;
  logic       locked;
  logic [2:0] dbg_state;
  logic [3:0] dbg_fail_cnt;

  key_loader dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .sin          (sin),
    .sin_valid    (sin_valid),
    .sin_ready    (sin_ready),
    .key_o        (key_o),
    .key_valid    (key_valid),
    .load_done    (load_done),
    .err          (err),
    .locked       (locked),
    .dbg_state    (dbg_state),
    .dbg_fail_cnt (dbg_fail_cnt)
  );

  // ---------------------------------------------------------------------------
  // Scoreboard
  // ---------------------------------------------------------------------------
  int n_checks = 0;
  int n_pass   = 0;
  int ld_seen  = 0;
  int err_seen = 0;
  int ld_exp   = 0;
  int err_exp  = 0;

  // Pulse counters: each pulse is one cycle wide, so each is counted once.
  always @(negedge clk) begin
    if (load_done) ld_seen++;
    if (err)       err_seen++;
  end

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // ---------------------------------------------------------------------------
  // Stimulus table
  // ---------------------------------------------------------------------------
  typedef struct {
    logic [7:0] pre;       // garbage bits before the header, MSB first
    int         pre_len;
    logic [8:0] key;
    logic       par;
    bit         gaps;      // insert sin_valid=0 gaps inside the frame
    logic       good;      // parity good -> commit expected
    logic [8:0] exp_key;
    logic [3:0] exp_fail;
    logic       exp_locked;
  } vec_t;

  localparam int NVEC = 8;
  vec_t vecs[NVEC];

  // ---------------------------------------------------------------------------
  // Driver tasks
  // ---------------------------------------------------------------------------
  task automatic idle(input int n);
    @(negedge clk);
    sin_valid = 1'b0;
    sin       = 1'($urandom);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Offers one bit and returns 1ns after the edge that accepted it.
  task automatic drive_bit(input logic b);
    int waited;
    waited = 0;
    @(negedge clk);
    while (!sin_ready && waited < 8) begin
      sin_valid = 1'b0;
      @(negedge clk);
      waited++;
    end
    if (!sin_ready) begin
      check("ready_timeout", 32'(sin_ready), 32'd1);
    end else begin
      sin       = b;
      sin_valid = 1'b1;
      @(posedge clk);
      #1;
      sin_valid = 1'b0;
    end
  endtask

  task automatic send_frame(input logic [7:0] pre, input int pre_len,
                            input logic [8:0] key, input logic par,
                            input bit gaps);
    logic [7:0] hdr;
    logic [18:0] body;
    hdr  = 8'hA5;
    body = {hdr, key, par, 1'b0};
    for (int i = pre_len - 1; i >= 0; i--) drive_bit(pre[i]);
    for (int k = 0; k < 18; k++) begin
      if (gaps && (k == 3 || k == 7 || k == 10 || k == 14 || k == 17))
        idle($urandom_range(1, 6));
      drive_bit(body[18-k]);
    end
  endtask

  // Holds reset for n edges and checks the reset values while it is held.
  task automatic do_reset(input int n, input string tag);
    @(negedge clk);
    rst_n     = 1'b0;
    sin_valid = 1'b0;
    repeat (n) @(posedge clk);
    #1;
    check({tag, "_key_o"},     32'(key_o),        32'h000);
    check({tag, "_key_valid"}, 32'(key_valid),    32'd0);
    check({tag, "_load_done"}, 32'(load_done),    32'd0);
    check({tag, "_err"},       32'(err),          32'd0);
    check({tag, "_locked"},    32'(locked),       32'd0);
    check({tag, "_fail_cnt"},  32'(dbg_fail_cnt), 32'd0);
    check({tag, "_state"},     32'(dbg_state),    32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check({tag, "_ready_after"}, 32'(sin_ready), 32'd1);
  endtask

  // ---------------------------------------------------------------------------
  // Test sequence
  // ---------------------------------------------------------------------------
  initial begin
    logic [8:0] key_before;
    logic [7:0] hdr;
    logic [8:0] k169;

    // key 1_0110_1001 has five ones -> parity 1; 0x0F0 has four -> parity 0;
    // 0x001 has one, so parity 0 is a bad frame.
    vecs[0] = '{8'h00, 0, 9'h169, 1'b1, 1'b0, 1'b1, 9'h169, 4'd0, 1'b0};
    vecs[1] = '{8'h05, 3, 9'h0F0, 1'b0, 1'b0, 1'b1, 9'h0F0, 4'd0, 1'b0};
    vecs[2] = '{8'h00, 0, 9'h169, 1'b1, 1'b1, 1'b1, 9'h169, 4'd0, 1'b0};
    vecs[3] = '{8'h00, 0, 9'h001, 1'b0, 1'b0, 1'b0, 9'h169, 4'd1, 1'b0};
    vecs[4] = '{8'h00, 0, 9'h0F0, 1'b0, 1'b0, 1'b1, 9'h0F0, 4'd0, 1'b0};
    vecs[5] = '{8'h00, 0, 9'h001, 1'b0, 1'b0, 1'b0, 9'h0F0, 4'd1, 1'b0};
    vecs[6] = '{8'h03, 2, 9'h100, 1'b0, 1'b0, 1'b0, 9'h0F0, 4'd2, 1'b0};
    vecs[7] = '{8'h00, 0, 9'h0FF, 1'b1, 1'b0, 1'b0, 9'h0F0, 4'd3, 1'b1};

    do_reset(2, "por");

    for (int i = 0; i < NVEC; i++) begin
      string t;
      t = $sformatf("v%0d", i);
      send_frame(vecs[i].pre, vecs[i].pre_len, vecs[i].key, vecs[i].par,
                 vecs[i].gaps);
      if (vecs[i].good) ld_exp++;
      else              err_exp++;
      // Just after the parity edge.
      check({t, "_load_done"}, 32'(load_done),    32'(vecs[i].good));
      check({t, "_err"},       32'(err),          32'(!vecs[i].good));
      check({t, "_key_o"},     32'(key_o),        32'(vecs[i].exp_key));
      check({t, "_key_valid"}, 32'(key_valid),    32'd1);
      check({t, "_fail_cnt"},  32'(dbg_fail_cnt), 32'(vecs[i].exp_fail));
      check({t, "_locked"},    32'(locked),       32'(vecs[i].exp_locked));
      check({t, "_ready"},     32'(sin_ready),
            32'(!vecs[i].good && !vecs[i].exp_locked));
      // One cycle later: pulses gone, COMMIT over.
      @(posedge clk);
      #1;
      check({t, "_load_done_drop"}, 32'(load_done), 32'd0);
      check({t, "_err_drop"},       32'(err),       32'd0);
      check({t, "_ready_next"},     32'(sin_ready), 32'(!vecs[i].exp_locked));
    end

    // Lockout: a full good frame offered with sin_valid held high changes
    // nothing.
    hdr  = 8'hA5;
    k169 = 9'h169;
    key_before = key_o;
    @(negedge clk);
    for (int k = 0; k < 18; k++) begin
      sin       = (k < 8) ? hdr[7-k] : ((k < 17) ? k169[16-k] : 1'b1);
      sin_valid = 1'b1;
      @(negedge clk);
    end
    sin_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    check("lock_key_hold",  32'(key_o),     32'(key_before));
    check("lock_key_o",     32'(key_o),     32'h0F0);
    check("lock_key_valid", 32'(key_valid), 32'd1);
    check("lock_locked",    32'(locked),    32'd1);
    check("lock_ready",     32'(sin_ready), 32'd0);
    check("lock_no_load",   32'(ld_seen),   32'(ld_exp));
    check("lock_no_err",    32'(err_seen),  32'(err_exp));

    do_reset(1, "unlock");

    // Reset mid-frame: commit, then abort a frame after four key bits.
    send_frame(8'h00, 0, 9'h169, 1'b1, 1'b0);
    ld_exp++;
    check("mid_pre_key", 32'(key_o), 32'h169);
    @(posedge clk);
    #1;
    for (int k = 7; k >= 0; k--) drive_bit(hdr[k]);
    for (int k = 8; k >= 5; k--) drive_bit(k169[k]);
    check("mid_state_data", 32'(dbg_state), 32'd1);
    do_reset(1, "mid");
    send_frame(8'h00, 0, 9'h0F0, 1'b0, 1'b0);
    ld_exp++;
    check("mid_fresh_load_done", 32'(load_done), 32'd1);
    check("mid_fresh_key_o",     32'(key_o),     32'h0F0);
    check("mid_fresh_key_valid", 32'(key_valid), 32'd1);
    @(posedge clk);
    #1;
    check("mid_fresh_ready_next", 32'(sin_ready), 32'd1);

    idle(3);
    check("total_load_done", 32'(ld_seen),  32'(ld_exp));
    check("total_err",       32'(err_seen), 32'(err_exp));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  // Safety net against a stuck run.
  initial begin
    #200000;
    $display("FAIL global_timeout: got %0d/%0d checks, expected completion",
             n_pass, n_checks);
    $fatal(1, "timeout");
  end

endmodule
